step_phase_monitor: RTL and testbench

Receive-side checker for the 4-phase one-hot stepper drive bus. It samples the A, B, /A, /B phase lines of one motor channel and decodes each legal phase advance into a step event with direction. It maintains a signed step position, measures step rate over a fixed gate window, and flags illegal or skipped phase patterns. One instance sits on each motor channel's phase outputs, for closed-loop bring-up and self-test.

---
 rtl/step_phase_monitor.sv | 176 +++++++++++++++++
 tb/tb_step_phase_monitor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/step_phase_monitor.sv
// Receive-side checker for a 4-phase one-hot stepper bus: decodes steps,
// tracks signed position, measures step rate and flags illegal/skipped phases.
module step_phase_monitor #(
    parameter int CLK_HZ      = 12000000,
    parameter int GATE_CYCLES = 12000000,
    parameter int FILT        = 4,
    parameter int POS_W       = 16,
    parameter int RATE_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        phase,
    input  logic              clr_pos,
    input  logic              clr_fault,
    output logic              step_pulse,
    output logic              dir,
    output logic [POS_W-1:0]  position,
    output logic [RATE_W-1:0] rate,
    output logic              rate_valid,
    output logic [1:0]        fault
);

    localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam int FW = $clog2(FILT + 1);

    localparam logic [FW-1:0] FILT_M1  = FW'(FILT - 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT);
    localparam logic [GW-1:0] GATE_END = GW'(GATE_CYCLES - 1);

    localparam logic [0:0] S_NOREF = 1'b0;
    localparam logic [0:0] S_TRACK = 1'b1;

    generate
        if (GATE_CYCLES < 2 || FILT < 1 || CLK_HZ < 1) begin : g_param_err
            $error("step_phase_monitor: invalid parameters");
        end
    endgenerate

    logic [3:0]        r_s1;
    logic [3:0]        r_s2;
    logic [3:0]        r_cand;
    logic [FW-1:0]     r_fcnt;
    logic [0:0]        r_state;
    logic [1:0]        r_idx;
    logic              r_step;
    logic              r_dir;
    logic [POS_W-1:0]  r_pos;
    logic [1:0]        r_fault;
    logic [GW-1:0]     r_gate;
    logic [RATE_W-1:0] r_scnt;
    logic [RATE_W-1:0] r_rate;
    logic              r_rate_vld;

    logic              w_acc;
    logic              w_legal;
    logic [1:0]        w_idx;
    logic [1:0]        w_diff;
    logic              w_track;
    logic              w_fwd;
    logic              w_rev;
    logic              w_skip;
    logic              w_gate_end;
    logic [RATE_W-1:0] w_scnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 4'b0000;
            r_s2 <= 4'b0000;
        end else begin
            r_s1 <= phase;
            r_s2 <= r_s1;
        end
    end

    // Counter saturates at FILT so a settled pattern fires w_acc only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= 4'b0000;
            r_fcnt <= '0;
        end else begin
            r_cand <= r_s2;
            if (r_s2 != r_cand) begin
                r_fcnt <= '0;
            end else if (r_fcnt != FILT_MAX) begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_acc = (r_s2 == r_cand) && (r_fcnt == FILT_M1);

    always_comb begin
        w_legal = 1'b1;
        w_idx   = 2'd0;
        case (r_cand)
            4'b1000: w_idx = 2'd0;
            4'b0100: w_idx = 2'd1;
            4'b0010: w_idx = 2'd2;
            4'b0001: w_idx = 2'd3;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_diff  = w_idx - r_idx;
    assign w_track = w_acc && w_legal && (r_state == S_TRACK);
    assign w_fwd   = w_track && (w_diff == 2'd1);
    assign w_rev   = w_track && (w_diff == 2'd3);
    assign w_skip  = w_track && (w_diff == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_NOREF;
            r_idx   <= 2'd0;
        end else if (w_acc) begin
            if (w_legal) begin
                r_state <= S_TRACK;
                r_idx   <= w_idx;
            end else begin
                r_state <= S_NOREF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            r_pos   <= '0;
            r_fault <= 2'b00;
        end else begin
            r_step <= w_fwd | w_rev;
            if (w_fwd | w_rev) begin
                r_dir <= w_rev;
            end
            if (clr_pos) begin
                r_pos <= '0;
            end else if (w_fwd) begin
                r_pos <= r_pos + 1'b1;
            end else if (w_rev) begin
                r_pos <= r_pos - 1'b1;
            end
            r_fault <= (clr_fault ? 2'b00 : r_fault)
                     | {w_skip, w_acc & ~w_legal};
        end
    end

    assign w_gate_end = (r_gate == GATE_END);
    assign w_scnt_nxt = (r_step && (r_scnt != '1)) ? r_scnt + 1'b1 : r_scnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate     <= '0;
            r_scnt     <= '0;
            r_rate     <= '0;
            r_rate_vld <= 1'b0;
        end else begin
            r_rate_vld <= w_gate_end;
            if (w_gate_end) begin
                r_gate <= '0;
                r_rate <= w_scnt_nxt;
                r_scnt <= '0;
            end else begin
                r_gate <= r_gate + 1'b1;
                r_scnt <= w_scnt_nxt;
            end
        end
    end

    assign step_pulse = r_step;
    assign dir        = r_dir;
    assign position   = r_pos;
    assign rate       = r_rate;
    assign rate_valid = r_rate_vld;
    assign fault      = r_fault;

endmodule

// File: tb/tb_step_phase_monitor.sv
// Directed self-checking bench for step_phase_monitor
// (GATE_CYCLES=100, FILT=4).
module tb_step_phase_monitor;

    logic        clk;
    logic        rst_n;
    logic [3:0]  phase;
    logic        clr_pos;
    logic        clr_fault;
    logic        step_pulse;
    logic        dir;
    logic [15:0] position;
    logic [15:0] rate;
    logic        rate_valid;
    logic [1:0]  fault;

    int n_cmp = 0;
    int n_err = 0;

    step_phase_monitor #(
        .CLK_HZ(12000000),
        .GATE_CYCLES(100),
        .FILT(4),
        .POS_W(16),
        .RATE_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .phase(phase),
        .clr_pos(clr_pos),
        .clr_fault(clr_fault),
        .step_pulse(step_pulse),
        .dir(dir),
        .position(position),
        .rate(rate),
        .rate_valid(rate_valid),
        .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset released on a negedge; caller drives phase right after.
    task automatic do_reset();
        rst_n     = 1'b0;
        phase     = 4'b0000;
        clr_pos   = 1'b0;
        clr_fault = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Holds a pattern; a step must appear exactly 7 edges after the change.
    task automatic drive(input string tag, input logic [3:0] pat,
                         input int cycles, input bit exp_step);
        int pcnt;
        int at;
        pcnt  = 0;
        at    = 0;
        phase = pat;
        for (int j = 1; j <= cycles; j++) begin
            @(negedge clk);
            if (step_pulse) begin
                pcnt++;
                at = j;
            end
        end
        chk(tag, 32'(pcnt * 16 + at), exp_step ? 32'd23 : 32'd0);
    endtask

    logic [3:0]  pats [4];
    logic [15:0] rv   [4];
    int          nrv;
    int          first_rv;
    int          c;

    initial begin
        pats[0] = 4'b1000;
        pats[1] = 4'b0100;
        pats[2] = 4'b0010;
        pats[3] = 4'b0001;

        do_reset();
        chk("rst_step", step_pulse, 0);
        chk("rst_dir", dir, 0);
        chk("rst_pos", position, 0);
        chk("rst_rate", rate, 0);
        chk("rst_rvld", rate_valid, 0);
        chk("rst_fault", fault, 0);

        drive("fw_ref", 4'b1000, 20, 0);
        drive("fw_s1", 4'b0100, 20, 1);
        drive("fw_s2", 4'b0010, 20, 1);
        drive("fw_s3", 4'b0001, 20, 1);
        drive("fw_s4", 4'b1000, 20, 1);
        chk("fw_dir", dir, 0);
        chk("fw_pos", position, 16'd4);
        chk("fw_fault", fault, 0);

        do_reset();
        drive("rv_ref", 4'b0001, 20, 0);
        drive("rv_s1", 4'b0010, 20, 1);
        drive("rv_s2", 4'b0100, 20, 1);
        drive("rv_s3", 4'b1000, 20, 1);
        chk("rv_dir", dir, 1);
        chk("rv_pos", position, 16'hFFFD);

        do_reset();
        drive("gl_ref", 4'b1000, 20, 0);
        drive("gl_glitch", 4'b0100, 3, 0);
        drive("gl_back", 4'b1000, 20, 0);
        chk("gl_fault", fault, 0);
        chk("gl_pos", position, 0);

        do_reset();
        drive("sk_ref", 4'b1000, 20, 0);
        drive("sk_skip", 4'b0010, 20, 0);
        chk("sk_fault", fault, 2'b10);
        chk("sk_pos", position, 0);
        drive("sk_fw", 4'b0001, 20, 1);
        chk("sk_pos1", position, 16'd1);
        chk("sk_dir", dir, 0);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        @(negedge clk);
        chk("sk_clr", fault, 0);

        do_reset();
        drive("il_ref", 4'b1000, 20, 0);
        drive("il_s1", 4'b0100, 20, 1);
        drive("il_zero", 4'b0000, 20, 0);
        chk("il_fault", fault, 2'b01);
        drive("il_reref", 4'b0100, 20, 0);
        drive("il_s2", 4'b0010, 20, 1);
        chk("il_pos", position, 16'd2);
        chk("il_fault2", fault, 2'b01);

        do_reset();
        nrv      = 0;
        first_rv = 0;
        for (int k = 0; k < 40; k++) begin
            phase = pats[(k + 1) % 4];
            for (int j = 1; j <= 10; j++) begin
                c = 10 * k + j;
                @(negedge clk);
                if (rate_valid) begin
                    if (nrv < 4) rv[nrv] = rate;
                    if (nrv == 0) first_rv = c;
                    nrv++;
                end
                if (c == 206) clr_pos = 1'b1;
                if (c == 207) begin
                    clr_pos = 1'b0;
                    chk("cp_step", step_pulse, 1);
                    chk("cp_pos", position, 0);
                end
            end
        end
        chk("rt_first", first_rv, 100);
        chk("rt_count", nrv, 4);
        chk("rt_w1", rv[0], 16'd9);
        chk("rt_w2", rv[1], 16'd10);
        chk("rt_w3", rv[2], 16'd10);
        chk("rt_w4", rv[3], 16'd10);
        chk("rt_pos", position, 16'd19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
